// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU op sequencer: control codes,
// instruction fields, FSM states, instruction classes and error codes.
package alu_seq_pkg;

    localparam logic [4:0] CT_NOP   = 5'b11111;
    localparam logic [4:0] CT_ADD   = 5'b00001;
    localparam logic [4:0] CT_ADDU  = 5'b01011;
    localparam logic [4:0] CT_SUB   = 5'b00010;
    localparam logic [4:0] CT_AND   = 5'b00011;
    localparam logic [4:0] CT_OR    = 5'b01000;
    localparam logic [4:0] CT_XOR   = 5'b00110;
    localparam logic [4:0] CT_SLT   = 5'b00111;
    localparam logic [4:0] CT_SHIFT = 5'b10010;
    localparam logic [4:0] CT_MFHI  = 5'b01100;
    localparam logic [4:0] CT_MFLO  = 5'b01101;
    localparam logic [4:0] CT_JR    = 5'b00000;
    localparam logic [4:0] CT_MULT  = 5'b01010;
    localparam logic [4:0] CT_DIV   = 5'b01001;
    localparam logic [4:0] CT_BEQ   = 5'b01111;
    localparam logic [4:0] CT_BNE   = 5'b01110;
    localparam logic [4:0] CT_BLEZ  = 5'b10000;
    localparam logic [4:0] CT_BGTZ  = 5'b10001;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_DIV_ZERO = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MD_ISSUE = 3'd2,
        ST_MD_WAIT  = 3'd3,
        ST_FINISH   = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'd0,
        CLS_MD      = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction classifier: opcode/funct -> ALU control code and
// instruction class. Unknown combinations come back as ILLEGAL with NOP code.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] code,
    output op_class_t  cls
);

    always_comb begin
        code = CT_NOP;
        cls  = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                cls = CLS_SINGLE;
                case (funct)
                    FN_ADD:  code = CT_ADD;
                    FN_ADDU: code = CT_ADDU;
                    FN_SUB:  code = CT_SUB;
                    FN_AND:  code = CT_AND;
                    FN_OR:   code = CT_OR;
                    FN_XOR:  code = CT_XOR;
                    FN_SLT:  code = CT_SLT;
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRAV: code = CT_SHIFT;
                    FN_MFHI: code = CT_MFHI;
                    FN_MFLO: code = CT_MFLO;
                    FN_JR:   code = CT_JR;
                    FN_MULT: begin
                        code = CT_MULT;
                        cls  = CLS_MD;
                    end
                    FN_DIV: begin
                        code = CT_DIV;
                        cls  = CLS_MD;
                    end
                    default: begin
                        code = CT_NOP;
                        cls  = CLS_ILLEGAL;
                    end
                endcase
            end
            OP_ADDI: begin
                code = CT_ADD;
                cls  = CLS_SINGLE;
            end
            OP_ADDIU, OP_LW, OP_SW: begin
                code = CT_ADDU;
                cls  = CLS_SINGLE;
            end
            OP_BEQ: begin
                code = CT_BEQ;
                cls  = CLS_SINGLE;
            end
            OP_BNE: begin
                code = CT_BNE;
                cls  = CLS_SINGLE;
            end
            OP_BLEZ: begin
                code = CT_BLEZ;
                cls  = CLS_SINGLE;
            end
            OP_BGTZ: begin
                code = CT_BGTZ;
                cls  = CLS_SINGLE;
            end
            default: begin
                code = CT_NOP;
                cls  = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle sequencer for the ALU control decoder: issues one control code
// per accepted instruction and waits on the mult/div unit for MD operations.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       md_done,
    input  logic       md_div_zero,
    output logic [4:0] controlType,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] dbg_state
);

    // Handshake: start is honoured only while busy is low; every output is a
    // flop, so a response is visible the cycle after the deciding edge.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MD_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [5:0]       funct_q, funct_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       ct_q, ct_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       errc_q, errc_d;

    logic [4:0]       dec_code;
    op_class_t        dec_cls;
    logic             is_div;

    alu_seq_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .code   (dec_code),
        .cls    (dec_cls)
    );

    assign is_div = (opcode_q == OP_RTYPE) && (funct_q == FN_DIV);

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        cnt_d    = cnt_q;
        ct_d     = CT_NOP;
        errc_d   = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opcode_d = opcode;
                    funct_d  = funct;
                    case (dec_cls)
                        CLS_SINGLE: begin
                            state_d = ST_EXEC;
                            ct_d    = dec_code;
                        end
                        CLS_MD: begin
                            state_d = ST_MD_ISSUE;
                            ct_d    = dec_code;
                        end
                        default: begin
                            state_d = ST_ERROR;
                            errc_d  = ERR_ILLEGAL;
                        end
                    endcase
                end
            end
            ST_MD_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
                // A result arriving on the limit edge takes priority over the timeout.
                if (md_done) begin
                    if (is_div && md_div_zero) begin
                        state_d = ST_ERROR;
                        errc_d  = ERR_DIV_ZERO;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = ST_ERROR;
                    errc_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_EXEC) || (state_d == ST_FINISH);
        err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            funct_q  <= '0;
            cnt_q    <= '0;
            ct_q     <= CT_NOP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            cnt_q    <= cnt_d;
            ct_q     <= ct_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
        end
    end

    assign controlType = ct_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = errc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: transaction-level reference model,
// per-cycle compare, directed literal checks and randomized traffic.
module tb_alu_op_sequencer;

    localparam int MD_TIMEOUT = 40;
    localparam logic [4:0] NOP = 5'b11111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       md_done = 1'b0;
    logic       md_div_zero = 1'b0;
    logic [4:0] controlType;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    bit run = 0;

    alu_op_sequencer #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .opcode      (opcode),
        .funct       (funct),
        .md_done     (md_done),
        .md_div_zero (md_div_zero),
        .controlType (controlType),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // instruction tables: value is the control code
    int rmap[int];
    int imap[int];
    logic [5:0] legal_op[$];
    logic [5:0] legal_fn[$];

    initial begin
        rmap[6'h20] = 5'b00001; rmap[6'h21] = 5'b01011; rmap[6'h22] = 5'b00010;
        rmap[6'h24] = 5'b00011; rmap[6'h25] = 5'b01000; rmap[6'h26] = 5'b00110;
        rmap[6'h2A] = 5'b00111; rmap[6'h00] = 5'b10010; rmap[6'h02] = 5'b10010;
        rmap[6'h03] = 5'b10010; rmap[6'h04] = 5'b10010; rmap[6'h07] = 5'b10010;
        rmap[6'h10] = 5'b01100; rmap[6'h12] = 5'b01101; rmap[6'h08] = 5'b00000;
        rmap[6'h18] = 5'b01010; rmap[6'h1A] = 5'b01001;
        imap[6'h08] = 5'b00001; imap[6'h09] = 5'b01011; imap[6'h23] = 5'b01011;
        imap[6'h2B] = 5'b01011; imap[6'h04] = 5'b01111; imap[6'h05] = 5'b01110;
        imap[6'h06] = 5'b10000; imap[6'h07] = 5'b10001;
        foreach (rmap[k]) begin
            legal_op.push_back(6'h00);
            legal_fn.push_back(6'(k));
        end
        foreach (imap[k]) begin
            legal_op.push_back(6'(k));
            legal_fn.push_back(6'($urandom_range(0, 63)));
        end
    end

    // {class, code}; class 0 single, 1 mult/div, 2 illegal
    function automatic logic [6:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (!rmap.exists(int'(fn))) return {2'd2, NOP};
            if (fn == 6'h18 || fn == 6'h1A) return {2'd1, 5'(rmap[int'(fn)])};
            return {2'd0, 5'(rmap[int'(fn)])};
        end
        if (imap.exists(int'(op))) return {2'd0, 5'(imap[int'(op)])};
        return {2'd2, NOP};
    endfunction

    // reference model: phase 0 accepting, 1 one response cycle, 2 waiting on mult/div
    typedef struct packed {
        logic [1:0] phase;
        logic [6:0] k;
        logic       div;
        logic [9:0] out;
    } mstate_t;

    localparam mstate_t M_RESET = '{phase: 2'd0, k: 7'd0, div: 1'b0, out: {NOP, 5'b0}};

    function automatic mstate_t model_step(input mstate_t s, input logic st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic mdd, input logic mdz);
        mstate_t    n;
        logic [6:0] r;
        logic [4:0] ct;
        logic       b, d, e;
        logic [1:0] c;
        n = s;
        ct = NOP; b = 1'b0; d = 1'b0; e = 1'b0; c = 2'b00;
        if (s.phase == 2'd0) begin
            if (st) begin
                r = ref_decode(op, fn);
                b = 1'b1;
                if (r[6:5] == 2'd2) begin
                    e = 1'b1; c = 2'b01; n.phase = 2'd1;
                end else if (r[6:5] == 2'd0) begin
                    ct = r[4:0]; d = 1'b1; n.phase = 2'd1;
                end else begin
                    ct = r[4:0]; n.phase = 2'd2; n.k = 7'd0; n.div = (fn == 6'h1A);
                end
            end
        end else if (s.phase == 2'd1) begin
            n.phase = 2'd0;
        end else begin
            n.k = s.k + 7'd1;
            b = 1'b1;
            if (int'(n.k) >= 2) begin
                if (mdd) begin
                    if (s.div && mdz) begin
                        e = 1'b1; c = 2'b10;
                    end else begin
                        d = 1'b1;
                    end
                    n.phase = 2'd1;
                end else if (int'(n.k) == MD_TIMEOUT + 1) begin
                    e = 1'b1; c = 2'b11; n.phase = 2'd1;
                end
            end
        end
        n.out = {ct, b, d, e, c};
        return n;
    endfunction

    mstate_t m = M_RESET;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= M_RESET;
        else m <= model_step(m, start, opcode, funct, md_done, md_div_zero);
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (run) begin
            total++;
            if ({controlType, busy, done, err, err_code} !== m.out) begin
                bad++;
                $display("FAIL cycle_compare t=%0t: got ct=%b busy=%b done=%b err=%b code=%b, want ct=%b busy=%b done=%b err=%b code=%b",
                         $time, controlType, busy, done, err, err_code,
                         m.out[9:5], m.out[4], m.out[3], m.out[2], m.out[1:0]);
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        start = 1'b1; opcode = op; funct = fn;
        @(negedge clk);
        start = 1'b0; opcode = 6'($urandom); funct = 6'($urandom);
    endtask

    // waits for done or err; n = negedges waited, -1 on expired bound
    task automatic wait_resp(output int n);
        n = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            total++; bad++;
            $display("FAIL wait_resp: no done/err within 60 cycles");
        end
    endtask

    int lat, nd0, blk_mode;

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk("reset_outputs", {controlType, busy, done, err, err_code}, {NOP, 5'b0});
        chk("reset_state", 10'(dbg_state), 10'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run = 1;

        // add
        do_start(6'h00, 6'h20);
        chk("add_code_done", {controlType, busy, done, err, err_code}, {5'b00001, 1'b1, 1'b1, 1'b0, 2'b00});
        @(negedge clk);
        chk("add_after", {controlType, busy, done, err, err_code}, {NOP, 5'b0});

        // div with md_done 5 cycles after issue
        do_start(6'h00, 6'h1A);
        chk("div_issue_code", 10'(controlType), 10'(5'b01001));
        repeat (5) @(negedge clk);
        chk("div_wait_nop", 10'({controlType, busy}), 10'({NOP, 1'b1}));
        md_done = 1'b1;
        wait_resp(lat);
        md_done = 1'b0;
        chk("div_done", 10'({done, err}), 10'(2'b10));
        @(negedge clk);
        chk("div_idle", 10'({busy, done}), 10'd0);

        // divide by zero, then mult with same inputs
        do_start(6'h00, 6'h1A);
        md_done = 1'b1; md_div_zero = 1'b1;
        wait_resp(lat);
        chk("divzero_err", 10'({done, err, err_code}), 10'(4'b0110));
        do_start(6'h00, 6'h18);
        chk("mult_issue_code", 10'(controlType), 10'(5'b01010));
        wait_resp(lat);
        chk("mult_zero_done", 10'({done, err, err_code}), 10'(4'b1000));
        chk("mult_min_latency", 10'(lat), 10'd1);
        md_done = 1'b0; md_div_zero = 1'b0;

        // timeout
        do_start(6'h00, 6'h18);
        repeat (MD_TIMEOUT) @(negedge clk);
        chk("timeout_not_yet", 10'(err), 10'd0);
        @(negedge clk);
        chk("timeout_err", 10'({err, err_code, busy}), 10'(4'b1111));
        @(negedge clk);
        chk("timeout_idle", 10'({busy, err}), 10'd0);

        // illegal opcode
        do_start(6'h3F, 6'h00);
        chk("illegal_err", {controlType, busy, done, err, err_code}, {NOP, 1'b1, 1'b0, 1'b1, 2'b01});

        // start pulsed during MD_WAIT is ignored
        nd0 = n_done;
        do_start(6'h00, 6'h18);
        repeat (3) @(negedge clk);
        start = 1'b1; opcode = 6'h00; funct = 6'h20;
        @(negedge clk);
        start = 1'b0;
        md_done = 1'b1;
        wait_resp(lat);
        md_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignored_start_one_done", 10'(n_done - nd0), 10'd1);

        // reset mid-operation
        do_start(6'h00, 6'h1A);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 10'(busy), 10'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset", {controlType, busy, done, err, err_code}, {NOP, 5'b0});
        @(negedge clk);
        reset_n = 1'b1;
        do_start(6'h05, 6'h00);
        chk("bne_after_reset", {controlType, busy, done, err, err_code}, {5'b01110, 1'b1, 1'b1, 1'b0, 2'b00});

        // randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            blk_mode = $urandom_range(0, 3);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) != 0) begin
                    int idx;
                    idx = $urandom_range(0, legal_op.size() - 1);
                    opcode = legal_op[idx];
                    funct = legal_fn[idx];
                end else begin
                    opcode = 6'($urandom);
                    funct = 6'($urandom);
                end
                md_done = (blk_mode == 0) ? 1'b0 : ($urandom_range(0, blk_mode * 4) == 0);
                md_div_zero = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        start = 1'b0; md_done = 1'b0;
        repeat (50) @(negedge clk);
        run = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multicycle sequencer that drives the 5-bit `controlType` bus of the ALU control decoder. It accepts one decoded instruction per handshake and issues the matching ALU/shift/HI-LO/branch-compare code for exactly one cycle. For `mult`/`div` it holds the decoder idle while waiting on the multiply/divide unit, and it reports completion or error back to the main control unit.

## Interface
Parameters:
- `MD_TIMEOUT`, default 40: maximum number of cycles spent in MD_WAIT before a timeout error.
- `CNT_W`, default 6: width of the wait counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `opcode`  in  6  instruction [31:26]; captured with `start`.
- `funct`  in  6  instruction [5:0]; captured with `start`.
- `md_done`  in  1  mult/div unit result ready (level, sampled in MD_WAIT).
- `md_div_zero`  in  1  divisor was zero; valid only with `md_done`.
- `controlType`  out  5  code to the ALU control decoder, registered.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  01 illegal, 10 divide-by-zero, 11 timeout, 00 otherwise.

## Operation
- NOP code is 5'b11111, which decodes to all-zero controls. It is driven in every state except EXEC and MD_ISSUE.
- R-type (opcode 0), by funct:
  - 0x20→00001, 0x21→01011, 0x22→00010, 0x24→00011, 0x25→01000, 0x26→00110, 0x2A→00111.
  - Shifts 0x00/0x02/0x03/0x04/0x07→10010.
  - 0x10→01100, 0x12→01101, 0x08→00000.
  - Mult/div: 0x18→01010 (MD class), 0x1A→01001 (MD class).
- I-type, by opcode:
  - 0x08→00001, 0x09→01011, 0x23/0x2B→01011.
  - Branch compares: 0x04→01111, 0x05→01110, 0x06→10000, 0x07→10001.
- Any other opcode/funct combination is ILLEGAL.
- States: IDLE, EXEC, MD_ISSUE, MD_WAIT, FINISH, ERROR.
- IDLE, on `start`:
  - SINGLE class → EXEC.
  - MD class → MD_ISSUE.
  - ILLEGAL → ERROR with code 01.
  - Without `start`, stay in IDLE.
- EXEC: drive the captured code; `done`=1; next state IDLE.
- MD_ISSUE: drive 01010 or 01001; clear the counter; next state MD_WAIT.
- MD_WAIT:
  - `md_done`=1 and `md_div_zero`=1 on a div → ERROR, code 10.
  - `md_done`=1 otherwise → FINISH. `md_div_zero` is ignored for mult.
  - Else, counter == MD_TIMEOUT-1 → ERROR, code 11.
  - Else increment the counter.
- FINISH: `done`=1; next state IDLE.
- ERROR: `err`=1 and `err_code` valid; next state IDLE.
- `start` outside IDLE is ignored and not queued. `opcode`/`funct` are don't-care after capture.
- Reset, including mid-operation, returns to IDLE with `controlType`=11111, `busy`=0, `done`=0, `err`=0, `err_code`=00, counter=0 and captured registers=0.

## Timing
- All outputs are registered from state, so there is no combinational path from inputs to outputs.
- SINGLE class: `start` sampled at edge N; code and `done` are high during cycle N+1; `busy` is high in cycle N+1 only. A new `start` can be accepted at edge N+2.
- MD class:
  - The MD code is high for the single cycle after acceptance.
  - `md_done` sampled high at edge M gives `done` during cycle M+1.
  - Minimum latency is 3 cycles from acceptance to `done`.
- Timeout: `err` is asserted MD_TIMEOUT+1 cycles after MD_ISSUE.
- If `md_done` is high on the same edge the counter reaches its limit, `md_done` wins.
- Illegal instruction: `err` is high in the cycle after `start`.

## Structure
- Shared package `alu_seq_pkg`:
  - controlType code constants, including NOP.
  - opcode and funct constants.
  - state enum.
  - class enum {SINGLE, MD, ILLEGAL}.
  - err_code constants.
- Sub-module `alu_seq_decode`: purely combinational; maps opcode/funct to {code, class}.
- The top level contains the FSM, capture registers, wait counter and output registers.

## Test plan
- **add:** `start` with opcode 0x00, funct 0x20 → `controlType`=00001 with `done`=1 for exactly one cycle, then 11111 and `busy`=0.
- **div with delay:** funct 0x1A, `md_done` raised 5 cycles after MD_ISSUE → 01001 for one cycle, NOP while waiting, then a single `done` pulse; `err` stays 0.
- **divide by zero / mult:** div with `md_done` and `md_div_zero`=1 → `err`=1, `err_code`=10, no `done`. The same inputs on a mult (0x18) → `done`, no `err`.
- **timeout:** mult with `md_done` never asserted → `err`=1, `err_code`=11 exactly 41 cycles after MD_ISSUE, then IDLE.
- **illegal and ignored start:**
  - opcode 0x3F → `err_code`=01 in the next cycle.
  - `start` pulsed during MD_WAIT → ignored, exactly one `done` observed.
- **reset mid-operation:** `reset_n` low during MD_WAIT → outputs return to reset values immediately (asynchronously). After release, bne (0x05) → 01110 with `done`.
